// File: rtl/timer_bus_master_if.sv
// Host command/response channels plus the req/gnt register bus of timer_periph.
// master = timer_bus_master side, slave = host + peripheral side.
interface timer_bus_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              req;
  logic              gnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              write_en;
  logic [DATA_W-1:0] rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, gnt, rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, req, addr, wdata, write_en
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, gnt, rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, req, addr, wdata, write_en
  );
endinterface

// File: rtl/timer_bus_master.sv
// Single-outstanding req/gnt bus initiator for timer_periph, all outputs registered.
// Optional grant timeout enabled by defining TIMER_MASTER_TIMEOUT_EN.
module timer_bus_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  timer_bus_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  state_t            state, state_n;
  logic              req_n, wen_n, cmd_ready_n, rsp_valid_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, rdata_n;
  logic              timeout;

`ifdef TIMER_MASTER_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q, err_n;

  // Counter idles at 0 outside REQ, so it is already cleared on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        wait_cnt <= '0;
    else if (state != REQ)            wait_cnt <= '0;
    else if (!bus.gnt)                wait_cnt <= wait_cnt + 8'd1;
  end

  assign timeout     = (state == REQ) && !bus.gnt &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign bus.rsp_err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_n;
  end
`else
  assign timeout     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    req_n       = bus.req;
    addr_n      = bus.addr;
    wdata_n     = bus.wdata;
    wen_n       = bus.write_en;
    rsp_valid_n = bus.rsp_valid;
    rdata_n     = bus.rsp_rdata;
`ifdef TIMER_MASTER_TIMEOUT_EN
    err_n       = err_q;
`endif
    case (state)
      IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
        state_n = REQ;
        req_n   = 1'b1;
        addr_n  = bus.cmd_addr;
        wdata_n = bus.cmd_wdata;
        wen_n   = bus.cmd_write;
      end
      REQ: if (bus.gnt || timeout) begin
        // A grant in the timeout cycle wins over the timeout.
        state_n     = RSP;
        req_n       = 1'b0;
        addr_n      = '0;
        wdata_n     = '0;
        wen_n       = 1'b0;
        rsp_valid_n = 1'b1;
        rdata_n     = (bus.gnt && !bus.write_en) ? bus.rdata : '0;
`ifdef TIMER_MASTER_TIMEOUT_EN
        err_n       = !bus.gnt;
`endif
      end
      RSP: if (bus.rsp_ready) begin
        state_n     = IDLE;
        rsp_valid_n = 1'b0;
        rdata_n     = '0;
`ifdef TIMER_MASTER_TIMEOUT_EN
        err_n       = 1'b0;
`endif
      end
      default: state_n = IDLE;
    endcase
    cmd_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.req       <= 1'b0;
      bus.addr      <= '0;
      bus.wdata     <= '0;
      bus.write_en  <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      state         <= state_n;
      bus.req       <= req_n;
      bus.addr      <= addr_n;
      bus.wdata     <= wdata_n;
      bus.write_en  <= wen_n;
      bus.cmd_ready <= cmd_ready_n;
      bus.rsp_valid <= rsp_valid_n;
      bus.rsp_rdata <= rdata_n;
    end
  end

endmodule

// File: doc/timer_bus_master.md
# timer_bus_master

Bus initiator for the timer peripheral's req/gnt register interface. Accepts single register commands from a host-side valid/ready port, drives `req`/`addr`/`wdata`/`write_en` toward the peripheral, and holds them stable until `gnt`. On grant it captures `rdata` and returns a response on a valid/ready response port. Sits between the test/host logic and `timer_periph`; one transaction is outstanding at a time.

## Interface

- `ADDR_W`, default `P_ADDR_WIDTH`: register address width.
- `DATA_W`, default `P_DATA_WIDTH`: register data width.
- `TIMEOUT_CYCLES`, default 16: maximum number of `req`-high cycles without `gnt`. Range 2..255. Only used with `TIMER_MASTER_TIMEOUT_EN`.

Ports (one clock; reset is asynchronous and active-high):

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: block can accept a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: register address.
- `cmd_wdata` in DATA_W: write data.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: host accepts the response.
- `rsp_rdata` out DATA_W: read data. Always 0 for writes and errors.
- `rsp_err` out 1: transaction timed out.
- `req` out 1: request to the peripheral.
- `gnt` in 1: grant from the peripheral. One-cycle pulse; `rdata` is valid in the same cycle.
- `addr` out ADDR_W: address to the peripheral.
- `wdata` out DATA_W: write data to the peripheral.
- `write_en` out 1: write strobe qualifier.
- `rdata` in DATA_W: read data from the peripheral.

## Operation

- FSM states: `IDLE`, `REQ`, `RSP`. All outputs are registered.
- `IDLE`: `cmd_ready=1`, `req=0`.
  - On `cmd_valid && cmd_ready`: latch `cmd_addr`/`cmd_wdata`/`cmd_write` onto `addr`/`wdata`/`write_en`, set `req=1`, go to `REQ`.
- `REQ`: `cmd_ready=0`. `req`, `addr`, `wdata` and `write_en` are held constant.
  - On `gnt==1`: `req<=0`. For a read, `rsp_rdata<=rdata`; for a write, `rsp_rdata<=0`. Set `rsp_err<=0`, `rsp_valid<=1`, go to `RSP`.
- `RSP`: `rsp_valid` stays high until `rsp_valid && rsp_ready`. Then `rsp_valid<=0`, `rsp_rdata<=0`, `rsp_err<=0`, go to `IDLE`.
- `addr`, `wdata` and `write_en` return to 0 when leaving `REQ`.
- `gnt` seen outside `REQ` is ignored. Such a spurious grant produces no response and no state change.
- `cmd_valid` is ignored outside `IDLE`. No command queueing.

## Timing

- Reset values: `req=0`, `addr=0`, `wdata=0`, `write_en=0`, `cmd_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, state `IDLE`.
- `cmd_ready` rises on the first clock edge after `reset` deasserts.
- Command accepted at edge N: `req` is high from N+1.
- `gnt` sampled high at edge M: `req` is low from M+1 and `rsp_valid` is high from M+1.
- Response handshake at edge K: `cmd_ready` is high from K+1.
- Minimum `req`-low gap between transactions is 2 cycles (RSP plus IDLE). This guarantees the peripheral sees `req` drop and returns to its idle state.
- Grant latency is peripheral-defined and variable (at least 2 cycles). The block tolerates any latency when timeout is disabled.
- Reset mid-transaction: `req` drops asynchronously, the command is discarded, and no response is issued.
- Back-to-back commands sustain one transaction per (grant latency + 3) cycles when `rsp_ready` is held at 1.

## Configuration

- Macro: `TIMER_MASTER_TIMEOUT_EN`.
- Defined:
  - An 8-bit wait counter clears on entry to `REQ` and increments each `REQ` cycle with `gnt=0`.
  - When the count reaches `TIMEOUT_CYCLES-1` and `gnt=0`: `req<=0`, `rsp_err<=1`, `rsp_rdata<=0`, `rsp_valid<=1`, go to `RSP`.
  - If `gnt=1` in the same cycle as the timeout condition, the grant wins and `rsp_err=0`.
- Undefined: no counter is present, `REQ` waits indefinitely, and `rsp_err` is tied to 0.

## Test plan

- Write then readback: write `P_ADDR_LOAD` = 0x0005, then read `P_ADDR_LOAD`. Expect the write response with `rsp_rdata=0`, `rsp_err=0`, then the read response with `rsp_rdata=0x0005`. `req` must be stable from acceptance to `gnt`.
- Timer run: write `P_ADDR_LOAD`=3, then write `P_ADDR_CONTROL` with the START bit set. Poll-read `P_ADDR_STATUS`. Expect `rsp_rdata=1` once, and the following read returns 0 (read-clear).
- Backpressure: hold `rsp_ready=0` for 10 cycles after a read. `rsp_valid` and `rsp_rdata` must stay constant, `cmd_ready=0`, and a second `cmd_valid` is ignored until the handshake.
- Timeout (macro on, `TIMEOUT_CYCLES`=4, `gnt` forced 0): `req` is high for exactly 4 cycles, then `rsp_err=1` and `rsp_rdata=0`. Then with `gnt` pulsed in the 4th cycle: `rsp_err=0`.
- Reset during `REQ`: assert `reset` two cycles after acceptance. `req` goes low immediately, no `rsp_valid` appears, and `cmd_ready` returns 1 one cycle after release.
- Spurious `gnt` pulse in `IDLE`: no `rsp_valid`, and the state stays `IDLE`.
